// File: rtl/cmd_decode_seq.sv
// cmd_decode_seq: handshaked command decoder with a load/store memory-request sequencer
module cmd_decode_seq #(
   parameter int DATA_W     = 8,
   parameter int REG_W      = 1,
   parameter int IMM_W      = 3,
   parameter int IMM_SIGNED = 0,
   parameter int MAX_WAIT   = 15,
   localparam int CMD_W     = 3 + 2*REG_W + IMM_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   input  logic [CMD_W-1:0]  cmd,
   output logic              cmd_ready,
   input  logic              mem_ack,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic              dec_valid,
   output logic [REG_W:0]    reg_sel0,
   output logic [REG_W:0]    reg_sel1,
   output logic [2:0]        reg_src,
   output logic [2:0]        alu_sel,
   output logic              alu_b_imm,
   output logic [DATA_W-1:0] imm_data,
   output logic              reg_we,
   output logic              extern_sel,
   output logic              stall,
   output logic              err
);
   localparam logic [2:0] OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_SHIFT = 3'd4;
   localparam logic [2:0] OP_LDR = 3'd5, OP_STR = 3'd6, OP_LDSP = 3'd7;
   localparam logic [2:0] SEL_ALU = 3'd4, SEL_EXTERN = 3'd5;
   localparam logic [REG_W:0] PC_SEL = (REG_W+1)'(2**REG_W);
   localparam logic [REG_W:0] LR_SEL = (REG_W+1)'(2**REG_W + 1);
   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   typedef struct packed {
      logic              dv;
      logic [REG_W:0]    sel0;
      logic [REG_W:0]    sel1;
      logic [2:0]        src;
      logic [2:0]        alu;
      logic              bimm;
      logic [DATA_W-1:0] imm;
      logic              we;
      logic              ext;
      logic              rd;
      logic              wr;
   } dec_t;

   state_t           r_state, w_nxt_state, w_dec_state;
   dec_t             r_dec, w_nxt, w_dec;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic             r_err, w_nxt_err;
   logic [2:0]       w_op;
   logic [REG_W-1:0] w_dst, w_src;
   logic [IMM_W-1:0] w_imm;
   logic             w_tmo;

   assign {w_op, w_dst, w_src, w_imm} = cmd;
   assign w_tmo = (MAX_WAIT != 0) && (r_cnt == MAX_C);

   // decode the presented command into its output fields and entry state
   always_comb begin
      w_dec = '0;
      w_dec.dv = 1'b1;
      w_dec.sel0 = {1'b0, w_dst};
      w_dec.sel1 = {1'b0, w_src};
      w_dec.imm = {{(DATA_W-IMM_W){IMM_SIGNED != 0 && w_imm[IMM_W-1]}}, w_imm};
      w_dec_state = S_EXEC;
      case (w_op)
         OP_ADD, OP_SUB, OP_MUL, OP_SHIFT: begin
            w_dec.src = SEL_ALU;
            w_dec.alu = w_op;
            w_dec.bimm = (w_dst == w_src);
            w_dec.we = 1'b1;
         end
         OP_LDR: begin
            w_dec.src = SEL_EXTERN;
            w_dec.rd = 1'b1;
            w_dec_state = S_MEM;
         end
         OP_STR: begin
            w_dec.wr = 1'b1;
            w_dec_state = S_MEM;
         end
         OP_LDSP: begin
            w_dec.sel0 = w_dst[0] ? PC_SEL : LR_SEL;
            w_dec.src = (w_dst != w_src) ? 3'(w_src) : SEL_EXTERN;
            w_dec.we = (w_dst != w_src);
            w_dec.rd = (w_dst == w_src);
            w_dec_state = (w_dst == w_src) ? S_MEM : S_EXEC;
         end
         default: ;
      endcase
   end

   // sequence memory ops: hold while waiting, write back on load ack, flag timeouts
   always_comb begin
      w_nxt = '0;
      w_nxt_state = S_IDLE;
      w_nxt_cnt = '0;
      w_nxt_err = 1'b0;
      if (r_state == S_MEM) begin
         if (mem_ack && r_dec.rd) begin
            w_nxt = r_dec;
            w_nxt.rd = 1'b0;
            w_nxt.we = 1'b1;
            w_nxt.ext = 1'b1;
            w_nxt.src = SEL_EXTERN;
            w_nxt_state = S_WB;
         end else if (!mem_ack && w_tmo) begin
            w_nxt_err = 1'b1;
         end else if (!mem_ack) begin
            w_nxt = r_dec;
            w_nxt_state = S_MEM;
            w_nxt_cnt = r_cnt + CNT_W'(1);
         end
      end else if (cmd_valid) begin
         w_nxt = w_dec;
         w_nxt_state = w_dec_state;
         w_nxt_cnt = CNT_W'(w_dec_state == S_MEM);
      end
   end

   // state, decoded fields, wait counter and error pulse registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_dec <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_dec <= w_nxt;
         r_cnt <= w_nxt_cnt;
         r_err <= w_nxt_err;
      end
   end

   assign cmd_ready  = (r_state != S_MEM);
   assign stall      = (r_state == S_MEM);
   assign mem_rd_req = r_dec.rd;
   assign mem_wr_req = r_dec.wr;
   assign dec_valid  = r_dec.dv;
   assign reg_sel0   = r_dec.sel0;
   assign reg_sel1   = r_dec.sel1;
   assign reg_src    = r_dec.src;
   assign alu_sel    = r_dec.alu;
   assign alu_b_imm  = r_dec.bimm;
   assign imm_data   = r_dec.imm;
   assign reg_we     = r_dec.we;
   assign extern_sel = r_dec.ext;
   assign err        = r_err;
endmodule

// File: tb/tb_cmd_decode_seq.sv
// tb_cmd_decode_seq: scoreboard bench for the command decoder and memory sequencer
module tb_cmd_decode_seq;
   localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3, SHIFT = 3'd4;
   localparam logic [2:0] LDR = 3'd5, STR = 3'd6, LDSP = 3'd7;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       mem_ack = 1'b0;
   logic [7:0] cmd = '0;
   logic       cmd_ready, mem_rd_req, mem_wr_req, dec_valid, alu_b_imm, reg_we, extern_sel, stall, err;
   logic [1:0] reg_sel0, reg_sel1;
   logic [2:0] reg_src, alu_sel;
   logic [7:0] imm_data;

   logic       v2 = 1'b0;
   logic       ack2 = 1'b0;
   logic [9:0] cmd2 = '0;
   logic       rdy2, rd2, wr2, dv2, bimm2, we2, ext2, stall2, err2;
   logic [2:0] s0_2, s1_2, src2, alu2;
   logic [7:0] imm2;

   int          n_total = 0;
   int          n_bad = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_v;
   logic [31:0] got_v;
   logic        acc;

   cmd_decode_seq #(.MAX_WAIT(4)) u_dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .mem_ack(mem_ack), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .dec_valid(dec_valid),
      .reg_sel0(reg_sel0), .reg_sel1(reg_sel1), .reg_src(reg_src), .alu_sel(alu_sel),
      .alu_b_imm(alu_b_imm), .imm_data(imm_data), .reg_we(reg_we), .extern_sel(extern_sel),
      .stall(stall), .err(err)
   );

   cmd_decode_seq #(.REG_W(2), .IMM_SIGNED(1)) u_dut2 (
      .clk(clk), .rstn(rstn), .cmd_valid(v2), .cmd(cmd2), .cmd_ready(rdy2),
      .mem_ack(ack2), .mem_rd_req(rd2), .mem_wr_req(wr2), .dec_valid(dv2),
      .reg_sel0(s0_2), .reg_sel1(s1_2), .reg_src(src2), .alu_sel(alu2),
      .alu_b_imm(bimm2), .imm_data(imm2), .reg_we(we2), .extern_sel(ext2),
      .stall(stall2), .err(err2)
   );

   always #5 clk = ~clk;

   assign got_v = {10'b0, reg_sel0, reg_sel1, reg_src, alu_sel, alu_b_imm, imm_data, reg_we, mem_rd_req, mem_wr_req};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mk(input logic [2:0] op, input logic d, input logic s, input logic [2:0] im);
      return {op, d, s, im};
   endfunction

   // first-cycle decode expected for REG_W=1, IMM_SIGNED=0: PC=2, LR=3, SEL_ALU=4, SEL_EXTERN=5
   function automatic logic [31:0] model(input logic [7:0] c);
      logic [2:0] op = c[7:5];
      logic       d = c[4];
      logic       s = c[3];
      logic [1:0] s0 = {1'b0, c[4]};
      logic [1:0] s1 = {1'b0, c[3]};
      logic [2:0] src = 3'd0;
      logic [2:0] alu = 3'd0;
      logic       b = 1'b0, we = 1'b0, rd = 1'b0, wr = 1'b0;
      if (op >= ADD && op <= SHIFT) begin
         src = 3'd4; alu = op; b = (d == s); we = 1'b1;
      end else if (op == LDR) begin
         src = 3'd5; rd = 1'b1;
      end else if (op == STR) begin
         wr = 1'b1;
      end else if (op == LDSP) begin
         s0 = d ? 2'd2 : 2'd3;
         if (d != s) begin src = {2'b0, s}; we = 1'b1; end
         else begin src = 3'd5; rd = 1'b1; end
      end
      return {10'b0, s0, s1, src, alu, b, 5'b0, c[2:0], we, rd, wr};
   endfunction

   task automatic send(input logic [7:0] c);
      cmd = c;
      cmd_valid = 1'b1;
      sb_q.push_back(model(c));
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      chk("send_ready", 32'(cmd_ready), 1);
      @(negedge clk);
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) acc <= 1'b0;
      else acc <= cmd_valid && cmd_ready;
   end

   always @(negedge clk) begin
      if (acc) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            chk("sb_dv", 32'(dec_valid), 1);
            chk("sb_dec", got_v, exp_v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_out", got_v, 0);
      chk("rst_flags", {dec_valid, stall, err, extern_sel}, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_dv", 32'(dec_valid), 0);
      send(mk(ADD, 1, 0, 0));
      send(mk(SUB, 0, 0, 5));
      send(mk(MUL, 1, 1, 7));
      send(mk(SHIFT, 0, 1, 2));
      send(mk(NOP, 1, 0, 3));
      cmd_valid = 1'b0;
      chk("nop_flags", {reg_we, mem_rd_req, mem_wr_req, stall}, 0);
      @(negedge clk);
      chk("idle_after", 32'(dec_valid), 0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack", {dec_valid, mem_rd_req, mem_wr_req, err, stall}, 0);
      send(mk(LDR, 0, 1, 0));
      cmd = mk(ADD, 0, 1, 4);
      cmd_valid = 1'b1;
      sb_q.push_back(model(cmd));
      for (int k = 1; k <= 3; k++) begin
         chk("ldr_rd", 32'(mem_rd_req), 1);
         chk("ldr_stall", 32'(stall), 1);
         chk("ldr_ready", 32'(cmd_ready), 0);
         chk("ldr_we", 32'(reg_we), 0);
         if (k == 3) mem_ack = 1'b1;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("wb_we_ext", {reg_we, extern_sel}, 2'b11);
      chk("wb_src", 32'(reg_src), 5);
      chk("wb_req", {mem_rd_req, stall}, 0);
      chk("wb_ready", 32'(cmd_ready), 1);
      chk("wb_dv", 32'(dec_valid), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("idle_after_wb", 32'(dec_valid), 0);
      send(mk(STR, 1, 0, 0));
      cmd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("str_wr", 32'(mem_wr_req), 1);
         chk("str_we_err", {reg_we, err}, 0);
         @(negedge clk);
      end
      chk("tmo_err", 32'(err), 1);
      chk("tmo_drop", {mem_wr_req, reg_we, stall}, 0);
      chk("tmo_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      chk("tmo_pulse", {err, dec_valid}, 0);
      send(mk(STR, 0, 1, 0));
      cmd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("stra_wr", 32'(mem_wr_req), 1);
         if (k == 4) mem_ack = 1'b1;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("ack_wins_err", 32'(err), 0);
      chk("ack_wins_idle", {mem_wr_req, dec_valid, reg_we, stall}, 0);
      send(mk(LDR, 1, 0, 0));
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("ldr_tmo_err", 32'(err), 1);
      chk("ldr_tmo_nowb", {reg_we, extern_sel, mem_rd_req}, 0);
      @(negedge clk);
      send(mk(LDSP, 1, 0, 0));
      send(mk(LDSP, 0, 0, 0));
      cmd_valid = 1'b0;
      chk("ldsp_mem_rd", {mem_rd_req, stall}, 2'b11);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("ldsp_wb", {reg_we, extern_sel}, 2'b11);
      chk("ldsp_wb_sel0", 32'(reg_sel0), 3);
      @(negedge clk);
      send(mk(LDR, 0, 1, 0));
      cmd_valid = 1'b0;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mem_drop", {mem_rd_req, stall, dec_valid}, 0);
      chk("rst_mem_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      rstn = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_no_wb", {reg_we, dec_valid, extern_sel}, 0);
         @(negedge clk);
      end
      send(mk(ADD, 0, 1, 6));
      cmd_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_out", got_v, 0);
      chk("rst_mid_flags", {dec_valid, cmd_ready}, 2'b01);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_rel_dv", 32'(dec_valid), 0);
      v2 = 1'b1;
      cmd2 = {ADD, 2'd2, 2'd1, 3'b111};
      @(negedge clk);
      chk("w2_imm", 32'(imm2), 8'hFF);
      chk("w2_sel", {s0_2, s1_2, alu2, bimm2}, {3'd2, 3'd1, 3'd1, 1'b0});
      cmd2 = {LDSP, 2'd1, 2'd3, 3'b001};
      @(negedge clk);
      chk("w2_ldsp_mv", {s0_2, src2, we2, rd2}, {3'd4, 3'd3, 1'b1, 1'b0});
      chk("w2_imm_pos", 32'(imm2), 8'h01);
      cmd2 = {LDSP, 2'd2, 2'd2, 3'b100};
      @(negedge clk);
      v2 = 1'b0;
      chk("w2_ldsp_mem", {s0_2, rd2, stall2}, {3'd5, 1'b1, 1'b1});
      chk("w2_imm_neg", 32'(imm2), 8'hFC);
      ack2 = 1'b1;
      @(negedge clk);
      ack2 = 1'b0;
      chk("w2_wb", {we2, ext2}, 2'b11);
      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
